// File: rtl/ahb_tty_uart_if.sv
// rtl/ahb_tty_uart_if.sv - AHB-Lite slave bundle for the tty console
interface ahb_tty_uart_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        hready;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready_resp;
    logic [1:0]  hresp;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hready, hwdata,
        input  hrdata, hready_resp, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hready, hwdata,
        output hrdata, hready_resp, hresp
    );
endinterface

// File: rtl/ahb_tty_uart.sv
// rtl/ahb_tty_uart.sv - AHB-Lite tty console: TX FIFO plus 8N1 UART serializer
// Optional macro TTY_SIM_PRINT_EN echoes pushed bytes in simulation.
module ahb_tty_uart #(
    parameter int          FIFO_DEPTH_LOG2 = 4,
    parameter logic [15:0] BAUD_DIV_RESET  = 16'd433
) (
    input  logic          HCLK,
    input  logic          HRESET,
    ahb_tty_uart_if.slave ex_i_ahb_AHB_Slave_TTY,
    output logic          uart_tx,
    output logic          tx_irq
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

    typedef enum logic [1:0] {D_IDLE, D_ACCESS, D_ERR1, D_ERR2} dstate_t;
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tstate_t;

    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic        hready;
    logic [31:0] hwdata;
    logic [48:0] unused_bus;

    assign hsel       = ex_i_ahb_AHB_Slave_TTY.hsel;
    assign haddr      = ex_i_ahb_AHB_Slave_TTY.haddr;
    assign htrans     = ex_i_ahb_AHB_Slave_TTY.htrans;
    assign hwrite     = ex_i_ahb_AHB_Slave_TTY.hwrite;
    assign hready     = ex_i_ahb_AHB_Slave_TTY.hready;
    assign hwdata     = ex_i_ahb_AHB_Slave_TTY.hwdata;
    assign unused_bus = {haddr[31:4], haddr[1:0], ex_i_ahb_AHB_Slave_TTY.hsize, hwdata[31:16]};

    dstate_t     d_state, d_next;
    logic [1:0]  reg_off, reg_off_next;
    logic        reg_write, reg_write_next;
    logic        accept, ready, push, baud_we;
    logic [1:0]  resp;
    logic [31:0] rdata, status;
    logic [15:0] baud_div;

    logic [7:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   level;
    logic                       full, empty, pop;

    tstate_t     t_state, t_next;
    logic [15:0] cnt, cnt_next, div_lat, div_next;
    logic [2:0]  bit_idx, idx_next;
    logic [7:0]  shreg, sh_next;
    logic        line_next, busy, bit_done;

    assign accept = hready & hsel & htrans[1];
    assign full   = level[FIFO_DEPTH_LOG2];
    assign empty  = (level == '0);
    assign busy   = (t_state != T_IDLE);
    assign tx_irq = empty & ~busy;

    assign ex_i_ahb_AHB_Slave_TTY.hrdata      = rdata;
    assign ex_i_ahb_AHB_Slave_TTY.hready_resp = ready;
    assign ex_i_ahb_AHB_Slave_TTY.hresp       = resp;

    always_comb begin
        status    = '0;
        status[0] = full;
        status[1] = empty;
        status[2] = busy;
        status[FIFO_DEPTH_LOG2+8:8] = level;
    end

    // Bus data phase; a new address phase is taken whenever this phase completes.
    always_comb begin
        d_next         = d_state;
        reg_off_next   = reg_off;
        reg_write_next = reg_write;
        ready          = 1'b1;
        resp           = 2'b00;
        push           = 1'b0;
        baud_we        = 1'b0;
        rdata          = '0;
        case (d_state)
            D_ACCESS: begin
                if (reg_write) begin
                    if (reg_off == 2'd0) begin
                        ready = ~full;
                        push  = ~full;
                    end else if (reg_off == 2'd2) begin
                        baud_we = 1'b1;
                    end
                end else begin
                    case (reg_off)
                        2'd1:    rdata = status;
                        2'd2:    rdata = {16'h0000, baud_div};
                        default: rdata = '0;
                    endcase
                end
            end
            D_ERR1: begin
                ready = 1'b0;
                resp  = 2'b01;
            end
            D_ERR2:  resp = 2'b01;
            default: ;
        endcase
        if (d_state == D_ERR1) begin
            d_next = D_ERR2;
        end else if (ready) begin
            if (accept) begin
                d_next         = (haddr[3:2] == 2'd3) ? D_ERR1 : D_ACCESS;
                reg_off_next   = haddr[3:2];
                reg_write_next = hwrite;
            end else begin
                d_next = D_IDLE;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            d_state   <= D_IDLE;
            reg_off   <= 2'd0;
            reg_write <= 1'b0;
            baud_div  <= BAUD_DIV_RESET;
        end else begin
            d_state   <= d_next;
            reg_off   <= reg_off_next;
            reg_write <= reg_write_next;
            if (baud_we) begin
                baud_div <= hwdata[15:0];
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= hwdata[7:0];
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    // Serializer; the divider is latched per character so BAUDDIV writes apply to the next one.
    always_comb begin
        bit_done = (cnt == div_lat);
        pop      = 1'b0;
        t_next   = t_state;
        cnt_next = cnt;
        div_next = div_lat;
        idx_next = bit_idx;
        sh_next  = shreg;
        case (t_state)
            T_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                end
            end
            T_START: begin
                if (bit_done) begin
                    t_next   = T_DATA;
                    cnt_next = '0;
                    idx_next = 3'd0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            T_DATA: begin
                if (bit_done) begin
                    cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        t_next = T_STOP;
                    end else begin
                        idx_next = bit_idx + 1'b1;
                        sh_next  = {1'b0, shreg[7:1]};
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                if (bit_done) begin
                    cnt_next = '0;
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        t_next = T_IDLE;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
        endcase
        if (pop) begin
            t_next   = T_START;
            cnt_next = '0;
            idx_next = 3'd0;
            sh_next  = mem[rd_ptr];
            div_next = baud_div;
        end
        case (t_next)
            T_START: line_next = 1'b0;
            T_DATA:  line_next = sh_next[0];
            default: line_next = 1'b1;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            t_state <= T_IDLE;
            cnt     <= '0;
            div_lat <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            uart_tx <= 1'b1;
        end else begin
            t_state <= t_next;
            cnt     <= cnt_next;
            div_lat <= div_next;
            bit_idx <= idx_next;
            shreg   <= sh_next;
            uart_tx <= line_next;
        end
    end

`ifdef TTY_SIM_PRINT_EN
    always_ff @(posedge HCLK) begin
        if (!HRESET && push) begin
            if (hwdata[7:0] == 8'h0D) begin
                $display("ahb_tty_uart: carriage return written, stopping simulation");
                $finish(2);
            end else begin
                $write("%c", hwdata[7:0]);
            end
        end
    end
`else
`endif

endmodule
